// File: rtl/instruction_fetch_pkg.sv
// Shared widths, PC step, reset-vector default and fetch FSM encoding
// for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int INSTRUCTION_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] PC_INCREMENT         = 32'd4;
  localparam logic [DATA_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } fetch_state_t;

  // Clears the byte-offset bits so a fetch address always names a whole word.
  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
    return addr & ~(DATA_WIDTH'(3));
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch stage with redirect support.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetchError and halts fetching.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req_valid,
  output logic [DATA_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic [DATA_WIDTH-1:0]        instructionPc,
  output logic                         instructionValid,
  input  logic                         instructionReady,
  input  logic                         pcOverwrite,
  input  logic [DATA_WIDTH-1:0]        pcTarget,
  output logic                         fetchError
);

  fetch_state_t            state, next_state;
  logic [DATA_WIDTH-1:0]   pc, next_pc;
  logic [DATA_WIDTH-1:0]   redirect_pc;
  logic                    discard, next_discard;
  logic                    load_out;
  logic                    bad_target;
  logic                    halted;

  assign redirect_pc = word_align(pcTarget);

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err;

  assign bad_target = pcOverwrite && (pcTarget[1:0] != 2'b00);
  assign halted     = fetch_err;
  assign fetchError = fetch_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (bad_target) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign bad_target = 1'b0;
  assign halted     = 1'b0;
  assign fetchError = 1'b0;
`endif

  assign imem_req_valid   = (state == ST_REQ);
  assign imem_req_addr    = pc;
  assign instructionValid = (state == ST_HOLD);

  // A redirect always retargets pc; the discard flag covers a request
  // already accepted by memory whose word belongs to the abandoned path.
  always_comb begin
    next_state   = state;
    next_pc      = pc;
    next_discard = discard;
    load_out     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (pcOverwrite) next_pc = redirect_pc;
        if (!halted)     next_state = ST_REQ;
      end
      ST_REQ: begin
        if (pcOverwrite) next_pc = redirect_pc;
        if (imem_req_ready) begin
          next_state = ST_WAIT;
          if (pcOverwrite) next_discard = 1'b1;
        end
      end
      ST_WAIT: begin
        if (pcOverwrite) next_pc = redirect_pc;
        if (imem_resp_valid) begin
          if (pcOverwrite || discard) begin
            next_discard = 1'b0;
            next_state   = ST_REQ;
          end else begin
            load_out   = 1'b1;
            next_state = ST_HOLD;
          end
        end else if (pcOverwrite) begin
          next_discard = 1'b1;
        end
      end
      ST_HOLD: begin
        if (pcOverwrite) begin
          next_pc    = redirect_pc;
          next_state = ST_REQ;
        end else if (instructionReady) begin
          next_pc    = pc + PC_INCREMENT;
          next_state = ST_REQ;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    if (bad_target) begin
      next_state   = ST_IDLE;
      next_pc      = pc;
      next_discard = 1'b0;
      load_out     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= RESET_VECTOR;
      discard <= 1'b0;
    end else begin
      state   <= next_state;
      pc      <= next_pc;
      discard <= next_discard;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instructionOut <= '0;
      instructionPc  <= '0;
    end else if (load_out) begin
      instructionOut <= imem_resp_data;
      instructionPc  <= pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: memory model, redirect
// driver, and a monitor predicting the consumed instruction stream.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instructionOut;
  logic [31:0] instructionPc;
  logic        instructionValid;
  logic        instructionReady;
  logic        pcOverwrite;
  logic [31:0] pcTarget;
  logic        fetchError;

  instruction_fetch #(.RESET_VECTOR(RV)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .instructionOut   (instructionOut),
    .instructionPc    (instructionPc),
    .instructionValid (instructionValid),
    .instructionReady (instructionReady),
    .pcOverwrite      (pcOverwrite),
    .pcTarget         (pcTarget),
    .fetchError       (fetchError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ready_pct      = 100;
  int resp_delay_max = 0;
  int consume_pct    = 100;
  int redirect_pct   = 0;

  bit          force_redirect = 1'b0;
  logic [31:0] force_target   = 32'h0;
  bit          stale_resp_inject = 1'b0;

  logic [31:0] redirect_q[$];
  logic [31:0] accepted_q[$];
  int          consumed = 0;
  bit          saw_wrap = 1'b0;
  logic [31:0] first_after_redirect = 32'hFFFF_FFFF;

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int rdy, input int dly, input int cons, input int redir, input int cycles);
    ready_pct      = rdy;
    resp_delay_max = dly;
    consume_pct    = cons;
    redirect_pct   = redir;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic pulseReset(input int cycles, input bit inject_stale);
    @(posedge clk); #2;
    reset = 1'b1;
    accepted_q.delete();
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b0;
    stale_resp_inject = inject_stale;
  endtask

  // Memory: accepts one request, answers after a random delay.
  initial begin : memory_model
    bit          accept;
    bit          pending;
    int          delay;
    logic [31:0] paddr;
    logic [31:0] snap;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    pending = 1'b0;
    delay   = 0;
    paddr   = 32'h0;
    forever begin
      @(negedge clk);
      accept = !reset && imem_req_valid && imem_req_ready;
      snap   = imem_req_addr;
      @(posedge clk); #1;
      if (reset) begin
        pending         = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
      end else begin
        if (accept) begin
          checkOutput("single_outstanding", {31'b0, pending}, 32'h0);
          accepted_q.push_back(snap);
          pending = 1'b1;
          paddr   = snap;
          delay   = $urandom_range(resp_delay_max, 0);
        end
        if (stale_resp_inject) begin
          imem_resp_valid   = 1'b1;
          imem_resp_data    = 32'hDEAD_BEEF;
          stale_resp_inject = 1'b0;
        end else if (pending && delay == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(paddr);
          pending         = 1'b0;
        end else begin
          imem_resp_valid = 1'b0;
          if (pending) delay--;
        end
        imem_req_ready = ($urandom_range(99, 0) < ready_pct);
      end
    end
  end

  // Downstream consumer and branch unit; every redirect is announced to the scoreboard.
  initial begin : driver
    logic [31:0] t;
    instructionReady = 1'b0;
    pcOverwrite      = 1'b0;
    pcTarget         = 32'h0;
    forever begin
      @(posedge clk); #1;
      instructionReady = ($urandom_range(99, 0) < consume_pct);
      pcOverwrite      = 1'b0;
      if (!reset) begin
        if (force_redirect) begin
          pcOverwrite    = 1'b1;
          pcTarget       = force_target;
          force_redirect = 1'b0;
          redirect_q.push_back(force_target & ~32'h3);
        end else if ($urandom_range(99, 0) < redirect_pct) begin
          t = $urandom & 32'h0000_0FFC;
`ifndef FETCH_ALIGN_CHECK_EN
          if ($urandom_range(3, 0) == 0) t = t | 32'($urandom_range(3, 0));
`endif
          pcOverwrite = 1'b1;
          pcTarget    = t;
          redirect_q.push_back(t & ~32'h3);
        end
      end
    end
  end

  // Reference: consumed stream runs pc, pc+4, ... and restarts at each redirect target.
  initial begin : monitor
    logic [31:0] exp_pc;
    logic [31:0] last_consumed;
    logic [31:0] prev_out;
    logic [31:0] prev_pc;
    logic [31:0] prev_addr;
    bit          prev_hold_stall;
    bit          prev_hold_redirect;
    bit          prev_req_stall;
    bit          after_redirect;
    exp_pc = RV;
    last_consumed = 32'h1;
    prev_out = 32'h0;
    prev_pc = 32'h0;
    prev_addr = 32'h0;
    prev_hold_stall = 1'b0;
    prev_hold_redirect = 1'b0;
    prev_req_stall = 1'b0;
    after_redirect = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_pc = RV;
        last_consumed = 32'h1;
        redirect_q.delete();
        prev_hold_stall = 1'b0;
        prev_hold_redirect = 1'b0;
        prev_req_stall = 1'b0;
        after_redirect = 1'b0;
      end else begin
        if (prev_hold_stall) begin
          checkOutput("hold_valid", {31'b0, instructionValid}, 32'h1);
          checkOutput("hold_data", instructionOut, prev_out);
          checkOutput("hold_pc", instructionPc, prev_pc);
        end
        if (prev_hold_redirect)
          checkOutput("hold_drop", {31'b0, instructionValid}, 32'h0);
        if (prev_req_stall) begin
          checkOutput("req_valid_held", {31'b0, imem_req_valid}, 32'h1);
          checkOutput("req_addr_held", imem_req_addr, prev_addr);
        end
        if (instructionValid)
          checkOutput("no_req_in_hold", {31'b0, imem_req_valid}, 32'h0);
`ifndef FETCH_ALIGN_CHECK_EN
        checkOutput("fetch_error_tied", {31'b0, fetchError}, 32'h0);
`endif
        if (pcOverwrite) begin
          if (redirect_q.size() == 0) begin
            checkOutput("redirect_queue", 32'h0, 32'h1);
          end else begin
            exp_pc = redirect_q.pop_front();
          end
          last_consumed  = 32'h1;
          after_redirect = 1'b1;
        end else if (instructionValid && instructionReady) begin
          checkOutput("instr_pc", instructionPc, exp_pc);
          checkOutput("instr_data", instructionOut, mem_word(exp_pc));
          if (exp_pc == 32'h0 && last_consumed == 32'hFFFF_FFFC) saw_wrap = 1'b1;
          if (after_redirect) first_after_redirect = exp_pc;
          after_redirect = 1'b0;
          last_consumed  = exp_pc;
          exp_pc         = exp_pc + 32'd4;
          consumed++;
        end
        prev_hold_stall    = instructionValid && !instructionReady && !pcOverwrite;
        prev_hold_redirect = instructionValid && pcOverwrite;
        prev_req_stall     = imem_req_valid && !imem_req_ready && !pcOverwrite;
        prev_out  = instructionOut;
        prev_pc   = instructionPc;
        prev_addr = imem_req_addr;
      end
    end
  end

  initial begin : main
    int consumed_before;
    reset = 1'b0;
    #2 reset = 1'b1;
    #10;
    checkOutput("rst_instr_valid", {31'b0, instructionValid}, 32'h0);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("rst_instr_out", instructionOut, 32'h0);
    checkOutput("rst_instr_pc", instructionPc, 32'h0);
    checkOutput("rst_fetch_error", {31'b0, fetchError}, 32'h0);
    checkOutput("rst_req_addr", imem_req_addr, RV);

    // Fully ready memory and consumer: sequential fetch from the reset vector.
    ready_pct = 100; resp_delay_max = 0; consume_pct = 100; redirect_pct = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    applyStimulus(100, 0, 100, 0, 14);
    checkOutput("seq_req_count_ok", {31'b0, accepted_q.size() >= 3}, 32'h1);
    if (accepted_q.size() >= 3) begin
      checkOutput("seq_req0", accepted_q[0], 32'h0);
      checkOutput("seq_req1", accepted_q[1], 32'h4);
      checkOutput("seq_req2", accepted_q[2], 32'h8);
    end
    checkOutput("seq_consumed_ok", {31'b0, consumed >= 3}, 32'h1);

    // Address wrap from the top of the address space.
    saw_wrap = 1'b0;
    force_target = 32'hFFFF_FFFC;
    force_redirect = 1'b1;
    applyStimulus(100, 1, 100, 0, 40);
    checkOutput("pc_wrap", {31'b0, saw_wrap}, 32'h1);

`ifndef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect target is word-aligned and fetching continues.
    first_after_redirect = 32'hFFFF_FFFF;
    force_target = 32'h0000_0102;
    force_redirect = 1'b1;
    applyStimulus(80, 2, 80, 0, 40);
    checkOutput("misaligned_forced", first_after_redirect, 32'h0000_0100);
`endif

    // Random traffic with a mid-transaction reset and a stale response after it.
    consumed_before = consumed;
    applyStimulus(60, 3, 60, 8, 800);
    pulseReset(2, 1'b1);
    applyStimulus(60, 3, 60, 8, 700);
    checkOutput("random_progress", {31'b0, (consumed - consumed_before) >= 50}, 32'h1);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect halts fetching with a sticky error.
    applyStimulus(100, 0, 100, 0, 10);
    @(posedge clk); #3;
    force_target = 32'h0000_0102;
    force_redirect = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("align_error_set", {31'b0, fetchError}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("align_halt_no_req", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("align_error_sticky", {31'b0, fetchError}, 32'h1);
    end
    pulseReset(2, 1'b0);
    @(negedge clk);
    checkOutput("align_error_cleared", {31'b0, fetchError}, 32'h0);
`endif

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0, PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_addr  output  DATA_WIDTH  byte address of requested word.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_resp_valid  input  1  response word present this cycle.
REQ-008 imem_resp_data  input  INSTRUCTION_WIDTH  fetched instruction word.
REQ-009 instructionOut  output  INSTRUCTION_WIDTH  instruction presented to decoder.
REQ-010 instructionPc  output  DATA_WIDTH  PC of instructionOut.
REQ-011 instructionValid  output  1  instructionOut/instructionPc are valid.
REQ-012 instructionReady  input  1  downstream consumes instruction this cycle.
REQ-013 pcOverwrite  input  1  redirect request (taken branch/jump).
REQ-014 pcTarget  input  DATA_WIDTH  redirect target address.
REQ-015 fetchError  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD; exactly one outstanding memory request at any time.
REQ-017 IDLE -> REQ unconditionally one cycle after reset deassertion.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT; addr held stable while valid and not ready, except on redirect.
REQ-019 WAIT: on imem_resp_valid, register word and pc into output regs, -> HOLD; instructionValid rises the cycle after resp (1-cycle latency from response).
REQ-020 HOLD: instructionValid=1, outputs stable; on instructionReady, pc <= pc+4 (mod 2^32, wrap to 0) and -> REQ next cycle.
REQ-021 Redirect in REQ without ready: pc <= pcTarget, stay REQ, new addr next cycle.
REQ-022 Redirect in REQ with ready same cycle: old address accepted, discard flag set, pc <= pcTarget, -> WAIT; flagged response dropped, then -> REQ at target.
REQ-023 Redirect in WAIT: discard flag set, pc <= pcTarget; response (same or later cycle) dropped, -> REQ; redirect coincident with resp also drops it.
REQ-024 Redirect in HOLD: held instruction dropped (instructionValid=0 next cycle), pc <= pcTarget, -> REQ; redirect wins over coincident instructionReady.
REQ-025 instructionValid never asserted for a discarded response.

Reset
REQ-026 On reset: state=IDLE, pc=RESET_VECTOR, imem_req_valid=0, instructionValid=0, instructionOut=0, instructionPc=0, discard flag=0, fetchError=0.
REQ-027 Reset asserted mid-transaction abandons it; any response arriving after reset release before the first new request is ignored.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN: when defined, redirect with pcTarget[1:0]!=0 sets fetchError (sticky until reset), FSM enters IDLE-halt and issues no further requests.
REQ-029 Without FETCH_ALIGN_CHECK_EN: fetchError tied 0; pcTarget[1:0] forced to 0 and fetch proceeds.

Structure
REQ-030 FSM state encodings, PC increment constant (4) and RESET_VECTOR default reside in shared globalVariables.v; DATA_WIDTH and INSTRUCTION_WIDTH taken from it.
REQ-031 Single module, no sub-module; PC register and output register in same module.

Verification
REQ-032 Reset release, memory ready/resp next cycle, instructionReady=1: requests at 0x0,0x4,0x8; instructionPc sequence 0,4,8 with matching data.
REQ-033 imem_req_ready low 3 cycles: imem_req_addr held 0x4 throughout, accepted on 4th cycle.
REQ-034 pcOverwrite=1, pcTarget=0x100 during WAIT: pending response dropped, next request addr 0x100, next instructionPc 0x100.
REQ-035 instructionReady low 5 cycles in HOLD: instructionOut stable, no new request issued; then redirect+ready same cycle -> next request at target.
REQ-036 pc=0xFFFFFFFC consumed: next request addr 0x0.
REQ-037 With FETCH_ALIGN_CHECK_EN, pcTarget=0x102: fetchError=1 next cycle, imem_req_valid stays 0 until reset.
